sme_feeder: RTL and testbench

SME_FEEDER -- requirements
Module: sme_feeder

---
 rtl/sme_pkg.sv | 40 ++++
 rtl/sme_char_buf.sv | 116 +++++++++++
 rtl/sme_feeder.sv | 241 ++++++++++++++++++++++++
 tb/tb_sme_feeder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// -----------------------------------------------------------------------------
// sme_pkg
// Definitions shared by the string-matching-engine feeder and the matcher:
//   - state_t       : feeder FSM state encoding
//   - STR_MAX_DEF   : default maximum string record length (bytes)
//   - PAT_MAX_DEF   : default maximum pattern record length (bytes)
//   - CH_*          : pattern metacharacters understood by the matcher
//   - addr_w/len_w  : width helpers for buffer index and length registers
// Build option: none in this file (see sme_feeder for SME_FEEDER_LEN_CHECK_EN).
// -----------------------------------------------------------------------------
package sme_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_STR = 3'd1,
        ST_LOAD_PAT = 3'd2,
        ST_SEND_STR = 3'd3,
        ST_SEND_PAT = 3'd4,
        ST_WAIT_RES = 3'd5
    } state_t;

    localparam int STR_MAX_DEF = 32;
    localparam int PAT_MAX_DEF = 8;

    localparam logic [7:0] CH_CARET  = 8'h5E;  // '^' anchor at string start
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$' anchor at string end
    localparam logic [7:0] CH_DOT    = 8'h2E;  // '.' any character
    localparam logic [7:0] CH_SPACE  = 8'h20;  // ' ' separator

    // Bits needed to address 'depth' entries (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold a count from 0 up to and including 'depth'.
    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sme_char_buf.sv
// -----------------------------------------------------------------------------
// sme_char_buf
// Double-banked byte buffer holding one record. Bytes of an incoming record are
// written into the bank that is not currently readable; i_commit makes that
// bank readable and latches its length. An abandoned record therefore never
// disturbs the previously committed one.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   i_wr_en         : write one byte (first byte of record when i_first=1)
//   i_first         : this byte starts a new record (written at index 0)
//   i_wr_data       : byte to write
//   i_commit        : record complete, publish it (may coincide with i_wr_en)
//   i_rd_addr       : read index into the committed record
//   o_rd_data       : registered read data (one cycle after i_rd_addr)
//   o_len           : committed record length (saturates at DEPTH)
//   o_ovf           : current record has exceeded DEPTH (only if CHECK_OVF)
// Bytes beyond DEPTH are silently dropped.
// -----------------------------------------------------------------------------
module sme_char_buf
    import sme_pkg::*;
#(
    parameter int  DEPTH     = STR_MAX_DEF,
    parameter bit  CHECK_OVF = 1'b0,
    localparam int AW        = addr_w(DEPTH),
    localparam int LW        = len_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic          i_first,
    input  logic [7:0]    i_wr_data,
    input  logic          i_commit,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic [LW-1:0] o_len,
    output logic          o_ovf
);

    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] w_ptr_next;
    logic [LW-1:0] r_len;
    logic          r_active;
    logic          w_full;
    logic          w_do_write;
    logic [AW-1:0] w_wr_addr;
    logic [7:0]    w_bank_rd [2];

    assign w_full     = (r_wr_ptr == LW'(DEPTH));
    assign w_do_write = i_wr_en & (i_first | ~w_full);
    assign w_wr_addr  = i_first ? '0 : r_wr_ptr[AW-1:0];

    always_comb begin
        w_ptr_next = r_wr_ptr;
        if (i_wr_en) begin
            if (i_first) begin
                w_ptr_next = LW'(1);
            end else if (!w_full) begin
                w_ptr_next = r_wr_ptr + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_len    <= '0;
            r_active <= 1'b0;
        end else begin
            r_wr_ptr <= w_ptr_next;
            if (i_commit) begin
                // Length includes a byte written in the same cycle.
                r_len    <= w_ptr_next;
                r_active <= ~r_active;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rd;

            always_ff @(posedge clk) begin
                if (w_do_write && (r_active != 1'(gi))) begin
                    r_mem[w_wr_addr] <= i_wr_data;
                end
                r_rd <= r_mem[i_rd_addr];
            end

            assign w_bank_rd[gi] = r_rd;
        end
    endgenerate

    assign o_rd_data = w_bank_rd[r_active];
    assign o_len     = r_len;

    generate
        if (CHECK_OVF) begin : g_ovf
            logic r_ovf;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_ovf <= 1'b0;
                end else if (i_wr_en) begin
                    r_ovf <= i_first ? 1'b0 : (r_ovf | w_full);
                end
            end

            // Include the byte being offered now so the decision is ready on in_last.
            assign o_ovf = ~i_first & (r_ovf | (i_wr_en & w_full));
        end else begin : g_no_ovf
            assign o_ovf = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sme_feeder.sv
// -----------------------------------------------------------------------------
// sme_feeder
// Collects string and pattern records from a host byte stream and feeds them
// to a string-matching engine: the stored string (only when newly loaded)
// followed back-to-back by the pattern, then waits for the engine's verdict
// and reports it with a running 8-bit sequence number.
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   in_valid/in_data/in_kind/
//   in_last/in_ready            : host record stream (kind 0 string, 1 pattern)
//   chardata/isstring/ispattern : byte stream towards the matcher
//   sme_valid/sme_match/
//   sme_index                   : matcher verdict
//   res_valid/res_match/
//   res_index/res_seq           : one-cycle result report
//   err                         : one-cycle record error pulse
// Build option: define SME_FEEDER_LEN_CHECK_EN to reject over-long records
// (err pulse, record discarded); otherwise over-long records are truncated.
// -----------------------------------------------------------------------------
module sme_feeder
    import sme_pkg::*;
#(
    parameter int STR_MAX = STR_MAX_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [7:0] res_seq,
    output logic       err
);

    localparam int STR_AW = addr_w(STR_MAX);
    localparam int STR_LW = len_w(STR_MAX);
    localparam int PAT_AW = addr_w(PAT_MAX);
    localparam int PAT_LW = len_w(PAT_MAX);
    localparam int IW     = (STR_LW > PAT_LW) ? STR_LW : PAT_LW;

`ifdef SME_FEEDER_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idx;
    logic            r_str_new;
    logic            r_str_loaded;
    logic            r_isstring;
    logic            r_ispattern;
    logic            r_err;
    logic            r_res_valid;
    logic            r_res_match;
    logic [4:0]      r_res_index;
    logic [7:0]      r_res_seq;
    logic [7:0]      r_count;

    logic            w_first;
    logic            w_kind;
    logic            w_accept;
    logic            w_rec_end;
    logic            w_str_wr;
    logic            w_pat_wr;
    logic            w_str_end;
    logic            w_pat_end;
    logic            w_str_commit;
    logic            w_pat_commit;
    logic            w_err_now;
    logic            w_str_last;
    logic            w_pat_last;
    logic            w_res_take;
    logic [7:0]      w_str_rd;
    logic [7:0]      w_pat_rd;
    logic [STR_LW-1:0] w_str_len;
    logic [PAT_LW-1:0] w_pat_len;
    logic            w_str_ovf;
    logic            w_pat_ovf;

    // Record kind comes from in_kind on the first byte only; afterwards the
    // load state remembers it.
    assign w_first   = (r_state == ST_IDLE);
    assign w_kind    = w_first ? in_kind : (r_state == ST_LOAD_PAT);
    assign w_accept  = in_valid & in_ready;
    assign w_rec_end = w_accept & in_last;
    assign w_str_wr  = w_accept & ~w_kind;
    assign w_pat_wr  = w_accept &  w_kind;
    assign w_str_end = w_rec_end & ~w_kind;
    assign w_pat_end = w_rec_end &  w_kind;

    assign w_str_commit = w_str_end & ~w_str_ovf;
    assign w_pat_commit = w_pat_end & ~w_pat_ovf & r_str_loaded;
    assign w_err_now    = (w_str_end & w_str_ovf)
                        | (w_pat_end & (w_pat_ovf | ~r_str_loaded));

    assign w_str_last = (r_idx == IW'(w_str_len) - IW'(1));
    assign w_pat_last = (r_idx == IW'(w_pat_len) - IW'(1));
    assign w_res_take = (r_state == ST_WAIT_RES) & sme_valid;

    sme_char_buf #(
        .DEPTH     (STR_MAX),
        .CHECK_OVF (LEN_CHECK)
    ) u_str_buf (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_str_wr),
        .i_first   (w_first),
        .i_wr_data (in_data),
        .i_commit  (w_str_commit),
        .i_rd_addr (r_idx[STR_AW-1:0]),
        .o_rd_data (w_str_rd),
        .o_len     (w_str_len),
        .o_ovf     (w_str_ovf)
    );

    sme_char_buf #(
        .DEPTH     (PAT_MAX),
        .CHECK_OVF (LEN_CHECK)
    ) u_pat_buf (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_pat_wr),
        .i_first   (w_first),
        .i_wr_data (in_data),
        .i_commit  (w_pat_commit),
        .i_rd_addr (r_idx[PAT_AW-1:0]),
        .o_rd_data (w_pat_rd),
        .o_len     (w_pat_len),
        .o_ovf     (w_pat_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a single-byte record finishes straight from IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_LOAD_STR, ST_LOAD_PAT: begin
                if (w_pat_commit) begin
                    w_state_next = r_str_new ? ST_SEND_STR : ST_SEND_PAT;
                end else if (w_rec_end) begin
                    w_state_next = ST_IDLE;
                end else if (w_accept && w_first) begin
                    w_state_next = w_kind ? ST_LOAD_PAT : ST_LOAD_STR;
                end
            end
            ST_SEND_STR: if (w_str_last) w_state_next = ST_SEND_PAT;
            ST_SEND_PAT: if (w_pat_last) w_state_next = ST_WAIT_RES;
            ST_WAIT_RES: if (sme_valid)  w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = 1'b0;
        chardata = 8'h00;
        case (r_state)
            ST_IDLE, ST_LOAD_STR, ST_LOAD_PAT: in_ready = 1'b1;
            default: ;
        endcase
        if (r_isstring) begin
            chardata = w_str_rd;
        end else if (r_ispattern) begin
            chardata = w_pat_rd;
        end
    end

    // Strobes are registered one cycle behind the send state so they line up
    // with the buffers' registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= '0;
            r_str_new    <= 1'b0;
            r_str_loaded <= 1'b0;
            r_isstring   <= 1'b0;
            r_ispattern  <= 1'b0;
            r_err        <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_match  <= 1'b0;
            r_res_index  <= '0;
            r_res_seq    <= '0;
            r_count      <= '0;
        end else begin
            if ((r_state == ST_SEND_STR && !w_str_last) ||
                (r_state == ST_SEND_PAT && !w_pat_last)) begin
                r_idx <= r_idx + IW'(1);
            end else begin
                r_idx <= '0;
            end

            if (w_str_commit) begin
                r_str_new    <= 1'b1;
                r_str_loaded <= 1'b1;
            end else if (r_state == ST_SEND_STR && w_str_last) begin
                r_str_new <= 1'b0;
            end

            r_isstring  <= (r_state == ST_SEND_STR);
            r_ispattern <= (r_state == ST_SEND_PAT);
            r_err       <= w_err_now;
            r_res_valid <= w_res_take;

            if (w_res_take) begin
                r_res_match <= sme_match;
                r_res_index <= sme_index;
                r_res_seq   <= r_count;
                r_count     <= r_count + 8'd1;
            end
        end
    end

    assign isstring  = r_isstring;
    assign ispattern = r_ispattern;
    assign err       = r_err;
    assign res_valid = r_res_valid;
    assign res_match = r_res_match;
    assign res_index = r_res_index;
    assign res_seq   = r_res_seq;

endmodule

// File: tb/tb_sme_feeder.sv
module tb_sme_feeder;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_kind;
    logic       in_last;
    logic       in_ready;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid;
    logic       sme_match;
    logic [4:0] sme_index;
    logic       res_valid;
    logic       res_match;
    logic [4:0] res_index;
    logic [7:0] res_seq;
    logic       err;

    sme_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_kind   (in_kind),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .chardata  (chardata),
        .isstring  (isstring),
        .ispattern (ispattern),
        .sme_valid (sme_valid),
        .sme_match (sme_match),
        .sme_index (sme_index),
        .res_valid (res_valid),
        .res_match (res_match),
        .res_index (res_index),
        .res_seq   (res_seq),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [8:0] mon_q[$];     // {is_pattern, byte}
    int         mon_c[$];     // cycle of each strobe
    int         cyc = 0;
    int         err_cnt = 0;
    int         res_cnt = 0;
    int         excl_viol = 0;
    int         zero_viol = 0;
    logic       last_match = 1'b0;
    logic [4:0] last_index = '0;
    logic [7:0] last_seq = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            if (isstring && ispattern) excl_viol <= excl_viol + 1;
            if (!isstring && !ispattern && chardata != 8'h00) zero_viol <= zero_viol + 1;
            if (isstring) begin
                mon_q.push_back({1'b0, chardata});
                mon_c.push_back(cyc);
            end else if (ispattern) begin
                mon_q.push_back({1'b1, chardata});
                mon_c.push_back(cyc);
            end
            if (err) err_cnt <= err_cnt + 1;
            if (res_valid) begin
                res_cnt    <= res_cnt + 1;
                last_match <= res_match;
                last_index <= res_index;
                last_seq   <= res_seq;
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [7:0] m_str[$];
    bit         m_loaded;
    bit         m_new;
    int         m_count;
    logic [7:0] rec [64];

    function automatic int set_rec(input string s);
        for (int i = 0; i < s.len(); i++) rec[i] = s[i];
        return s.len();
    endfunction

    task automatic model_reset();
        m_str.delete();
        m_loaded = 1'b0;
        m_new    = 1'b0;
        m_count  = 0;
    endtask

    task automatic send_bytes(input bit kind, input int n, input bit gaps);
        int t;
        int g;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = rec[i];
            in_kind  = (i == 0) ? kind : 1'($urandom);
            in_last  = (i == n - 1);
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("ready_timeout", 32'(t), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_kind  = 1'b0;
    endtask

    // One record end to end: model prediction, stimulus, matcher reply, checks.
    // res_m < 0 picks a random matcher verdict.
    task automatic do_record(input bit kind, input int n, input bit gaps,
                             input string tag, input int res_m, input int res_i);
        logic [8:0] exp_q[$];
        bit         exp_err;
        bit         exp_res;
        int         np;
        int         base_q;
        int         base_err;
        int         base_res;
        int         t;
        logic       m;
        logic [4:0] ix;

        exp_err = 1'b0;
        exp_res = 1'b0;
        if (!kind) begin
            if (n > STR_MAX) begin
`ifdef SME_FEEDER_LEN_CHECK_EN
                exp_err = 1'b1;
`else
                m_str.delete();
                for (int i = 0; i < STR_MAX; i++) m_str.push_back(rec[i]);
                m_new = 1'b1;
                m_loaded = 1'b1;
`endif
            end else begin
                m_str.delete();
                for (int i = 0; i < n; i++) m_str.push_back(rec[i]);
                m_new = 1'b1;
                m_loaded = 1'b1;
            end
        end else begin
            if (!m_loaded) exp_err = 1'b1;
`ifdef SME_FEEDER_LEN_CHECK_EN
            else if (n > PAT_MAX) exp_err = 1'b1;
`endif
            else begin
                if (m_new) foreach (m_str[i]) exp_q.push_back({1'b0, m_str[i]});
                np = (n > PAT_MAX) ? PAT_MAX : n;
                for (int i = 0; i < np; i++) exp_q.push_back({1'b1, rec[i]});
                exp_res = 1'b1;
                m_new = 1'b0;
            end
        end

        base_q   = mon_q.size();
        base_err = err_cnt;
        base_res = res_cnt;
        send_bytes(kind, n, gaps);

        t = 0;
        while ((mon_q.size() - base_q) < exp_q.size() && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "/strobe_timeout"}, 32'(t < 300), 1);

        // Matcher reply; outside WAIT_RES it must be ignored.
        m  = (res_m < 0) ? 1'($urandom) : 1'(res_m);
        ix = (res_m < 0) ? 5'($urandom) : 5'(res_i);
        @(negedge clk);
        sme_valid = 1'b1;
        sme_match = m;
        sme_index = ix;
        @(negedge clk);
        sme_valid = 1'b0;
        sme_match = 1'b0;
        sme_index = '0;
        repeat (6) @(posedge clk);

        chk({tag, "/nbytes"}, 32'(mon_q.size() - base_q), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_q + i < mon_q.size())
                chk($sformatf("%s/byte%0d", tag, i), 32'(mon_q[base_q + i]), 32'(exp_q[i]));
        end
        if (exp_q.size() > 0 && (mon_q.size() - base_q) == exp_q.size())
            chk({tag, "/contiguous"},
                32'(mon_c[base_q + exp_q.size() - 1] - mon_c[base_q]), 32'(exp_q.size() - 1));
        chk({tag, "/err"}, 32'(err_cnt - base_err), 32'(exp_err));
        chk({tag, "/nres"}, 32'(res_cnt - base_res), 32'(exp_res));
        if (exp_res) begin
            chk({tag, "/res_match"}, 32'(last_match), 32'(m));
            chk({tag, "/res_index"}, 32'(last_index), 32'(ix));
            chk({tag, "/res_seq"}, 32'(last_seq), 32'(8'(m_count)));
            m_count++;
        end
        chk({tag, "/exclusive"}, 32'(excl_viol), 0);
        chk({tag, "/idle_zero"}, 32'(zero_viol), 0);
        $display("rec %s kind=%0d len=%0d sent=%0d err=%0d res=%0d",
                 tag, kind, n, mon_q.size() - base_q, err_cnt - base_err, res_cnt - base_res);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/in_ready"}, 32'(in_ready), 1);
        chk({tag, "/isstring"}, 32'(isstring), 0);
        chk({tag, "/ispattern"}, 32'(ispattern), 0);
        chk({tag, "/chardata"}, 32'(chardata), 0);
        chk({tag, "/res_valid"}, 32'(res_valid), 0);
        chk({tag, "/res_match"}, 32'(res_match), 0);
        chk({tag, "/res_index"}, 32'(res_index), 0);
        chk({tag, "/res_seq"}, 32'(res_seq), 0);
        chk({tag, "/err"}, 32'(err), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        int base_q;
        int base_res;
        bit kd;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_kind = 1'b0; in_last = 1'b0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
        model_reset();
        #1;
        chk_reset_outputs("por");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Pattern with no string ever loaded.
        n = set_rec("a");
        do_record(1'b1, n, 1'b0, "nostr", -1, 0);
        // String "abc", pattern "b", matcher hit at index 1.
        n = set_rec("abc");
        do_record(1'b0, n, 1'b0, "str_abc", -1, 0);
        n = set_rec("b");
        do_record(1'b1, n, 1'b0, "pat_b", 1, 1);
        // Reuse of the stored string.
        n = set_rec("x");
        do_record(1'b1, n, 1'b0, "pat_x", 0, 0);
        // Anchored pattern with stuttering in_valid.
        n = set_rec("^ab$");
        do_record(1'b1, n, 1'b1, "pat_anch", -1, 0);
        // Over-long string, then a pattern.
        for (int i = 0; i < 33; i++) rec[i] = 8'(8'h41 + (i % 26));
        do_record(1'b0, 33, 1'b0, "str_33", -1, 0);
        n = set_rec("q");
        do_record(1'b1, n, 1'b0, "pat_after33", -1, 0);

        // Randomized records.
        for (int k = 0; k < 24; k++) begin
            kd = ($urandom_range(0, 2) != 0);
            n  = kd ? $urandom_range(1, PAT_MAX + 3) : $urandom_range(1, STR_MAX + 3);
            for (int i = 0; i < n; i++) rec[i] = 8'($urandom_range(32, 126));
            do_record(kd, n, 1'($urandom), $sformatf("rnd%0d", k), -1, 0);
        end

        // Reset in the middle of sending the string.
        n = set_rec("hello");
        do_record(1'b0, n, 1'b0, "str_hello", -1, 0);
        n = set_rec("l");
        base_q   = mon_q.size();
        base_res = res_cnt;
        send_bytes(1'b1, n, 1'b0);
        t = 0;
        while ((mon_q.size() - base_q) < 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("midreset/reach_byte2", 32'(t < 100), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset_async");
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset_edge");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        chk("midreset/no_result", 32'(res_cnt - base_res), 0);
        n = set_rec("a");
        do_record(1'b1, n, 1'b0, "after_reset_pat", -1, 0);
        n = set_rec("abc");
        do_record(1'b0, n, 1'b0, "after_reset_str", -1, 0);
        n = set_rec("c");
        do_record(1'b1, n, 1'b0, "after_reset_pat2", 1, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
